apogee_mem_arb: RTL and testbench
=================================

# apogee_mem_arb

Single-port memory arbiter that shares the SDRAM byte interface between three requesters: the loader (ioctl download writes), the video DMA (character fetches during HLDA), and the CPU (reads/writes, including extended ROM-disk reads through the PPA2 window). Each requester issues one-cycle strobes. The arbiter queues at most one transaction per requester, grants by fixed priority with a CPU anti-starvation guard, and sequences one memory transaction at a time. It returns a per-requester acknowledge pulse and holds the read data. It sits between the core's address/data muxing and the `sram` block, replacing its ad-hoc `ioctl_download ? … : hlda ? … :` selection.

## Interface
Parameters:
- `AW`, 25: memory address width.
- `STARVE_MAX`, 4: number of consecutive non-CPU grants allowed while a CPU request is pending.

Ports:
- `clk` in 1: system clock (clk_sys, 50 MHz). It is the only clock.
- `reset` in 1: synchronous, active-high reset.
- `io_req` in 1: loader strobe, one cycle wide, write only.
- `io_addr` in AW: loader address.
- `io_din` in 8: loader write data.
- `io_ack` out 1: loader done pulse.
- `dma_req` in 1: DMA read strobe.
- `dma_addr` in AW: DMA address.
- `dma_dout` out 8: DMA read data.
- `dma_ack` out 1: DMA done pulse.
- `cpu_req` in 1: CPU strobe.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in AW: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: CPU read data.
- `cpu_ack` out 1: CPU done pulse.
- `mem_req` out 1: command to memory, held until `mem_ack`.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW: memory address.
- `mem_din` out 8: memory write data.
- `mem_dout` in 8: memory read data, valid in the `mem_ack` cycle.
- `mem_ack` in 1: memory completion pulse.
- `grant_id` out 2: current owner (0 none, 1 io, 2 dma, 3 cpu).
- `busy` out 1: state is not IDLE.

## Operation
- Port slots:
  - A strobe sets that port's `pending` flag and captures the port's addr, din and we.
  - A strobe arriving while `pending` is set overwrites the captured values (latest wins). Only one transaction results.
  - A strobe arriving in the same cycle the slot is granted is a new request. It re-sets `pending` after the grant consumes the old one.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE → ISSUE when any pending flag is set. The arbiter selects the winner, loads `mem_*` from the winner's slot, clears its pending flag, sets `grant_id`, and asserts `mem_req`.
  - ISSUE holds `mem_req`, `mem_addr`, `mem_we` and `mem_din` stable until `mem_ack`. On `mem_ack` it latches `mem_dout` into the owner's read register (reads only) and goes to DONE.
  - DONE pulses the owner's ack for one cycle, drops `mem_req`, sets `grant_id` to 0, and returns to IDLE.
- Priority: io > dma > cpu.
  - `starve` counter (3 bits): increments on each io or dma grant while CPU is pending. It clears on any CPU grant, and whenever CPU is not pending.
  - When `starve == STARVE_MAX` and CPU is pending, CPU wins regardless of the other requesters.
- Write transactions leave `cpu_dout`/`dma_dout` unchanged.
- A `mem_ack` received in IDLE or DONE is ignored.

## Timing
- Reset values: all outputs 0, all pending flags 0, `starve` 0, state IDLE.
- Reset asserted mid-transaction aborts it. `mem_req` is 0 in the cycle after reset is asserted, and a late `mem_ack` is ignored.
- Request flow, with the strobe in cycle N:
  - `pending` is visible in N+1.
  - `mem_req` is high from N+2 (ISSUE, if the slot wins in IDLE).
  - If `mem_ack` arrives in cycle M: port ack and read data are valid in M+1, and `mem_req` is low in M+1.
  - The next grant's `mem_req` can rise in M+2.
- Minimum strobe→ack latency is 3 cycles plus memory latency. Back-to-back transactions have one dead cycle between them.
- Read data registers hold their value until the next read completes for that port.

## Structure
- Package `apogee_mem_pkg`:
  - `typedef enum {IDLE, ISSUE, DONE}` for the state.
  - Requester-ID constants `GID_NONE`, `GID_IO`, `GID_DMA`, `GID_CPU`.
  - Default `AW`.
- Sub-module `mem_arb_slot`: pending flag, capture registers, read-data register. It is instantiated three times; the loader slot ties `we=1`.
- The top holds the FSM, the priority/starvation selector and the output registers.

## Test plan
- CPU read at 0x00123, memory returns 0x5A after 2 cycles → `mem_req` high cycles N+2..N+4, `cpu_ack` in N+5, `cpu_dout` = 0x5A.
- `io_req` and `cpu_req` strobed in the same cycle → io is served first (`grant_id` = 1), then cpu (`grant_id` = 3). Each ack occurs exactly once.
- DMA and io strobed continuously while one CPU read is pending, `STARVE_MAX` = 4 → CPU granted on the 5th grant, `starve` back to 0.
- Two `cpu_req` strobes while pending (addr 0x10, then 0x20) → one memory read at 0x20, one `cpu_ack`.
- Reset asserted in ISSUE, then `mem_ack` arrives 2 cycles later → no port ack, all outputs 0, state IDLE.
- DMA read returns 0x33, then a CPU write of 0x77 completes → `dma_dout` stays 0x33, `cpu_dout` unchanged, `mem_we` = 1 only for the CPU transaction.

Source files
------------

// File: rtl/apogee_mem_pkg.sv
// Shared types and constants for the apogee memory arbiter.
// Owner encoding matches the grant_id output.
package apogee_mem_pkg;

  localparam int AW_DEFAULT = 25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam logic [1:0] GID_NONE = 2'd0;
  localparam logic [1:0] GID_IO   = 2'd1;
  localparam logic [1:0] GID_DMA  = 2'd2;
  localparam logic [1:0] GID_CPU  = 2'd3;

  // Fixed priority io > dma > cpu, unless the starvation guard forces the CPU through.
  function automatic logic [1:0] pick_winner(input logic io_p, input logic dma_p,
                                             input logic cpu_p, input logic cpu_force);
    if (cpu_force)  return GID_CPU;
    else if (io_p)  return GID_IO;
    else if (dma_p) return GID_DMA;
    else if (cpu_p) return GID_CPU;
    else            return GID_NONE;
  endfunction

endpackage

// File: rtl/apogee_mem_arb_slot.sv
// One requester slot: pending flag, captured command and the port's read-data register.
// A new strobe always wins over a grant in the same cycle, so it re-arms pending.
module mem_arb_slot
  import apogee_mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          grant,
  input  logic          rd_load,
  input  logic [7:0]    rd_data,
  output logic          pending,
  output logic          cap_we,
  output logic [AW-1:0] cap_addr,
  output logic [7:0]    cap_din,
  output logic [7:0]    dout
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= 1'b0;
      cap_we   <= 1'b0;
      cap_addr <= '0;
      cap_din  <= 8'h00;
      dout     <= 8'h00;
    end else begin
      if (req) begin
        pending  <= 1'b1;
        cap_we   <= we;
        cap_addr <= addr;
        cap_din  <= din;
      end else if (grant) begin
        pending <= 1'b0;
      end
      if (rd_load) dout <= rd_data;
    end
  end

endmodule

// File: rtl/apogee_mem_arb.sv
// Three-way SDRAM byte-port arbiter: loader, video DMA and CPU share one memory command path,
// one transaction in flight, fixed priority with a CPU starvation guard.
module apogee_mem_arb
  import apogee_mem_pkg::*;
#(
  parameter int AW         = AW_DEFAULT,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          io_req,
  input  logic [AW-1:0] io_addr,
  input  logic [7:0]    io_din,
  output logic          io_ack,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic [7:0]    dma_dout,
  output logic          dma_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  input  logic [7:0]    mem_dout,
  input  logic          mem_ack,
  output logic [1:0]    grant_id,
  output logic          busy
);

  arb_state_t state;
  logic [2:0] starve;

  logic          io_pend, dma_pend, cpu_pend;
  logic          io_cwe, dma_cwe, cpu_cwe;
  logic [AW-1:0] io_caddr, dma_caddr, cpu_caddr;
  logic [7:0]    io_cdin, dma_cdin, cpu_cdin;
  logic [7:0]    io_dout_unused;

  logic          any_pend, cpu_force, can_grant, rd_done;
  logic [1:0]    winner;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [7:0]    sel_din;

  assign any_pend  = io_pend | dma_pend | cpu_pend;
  assign cpu_force = cpu_pend && (starve == 3'(STARVE_MAX));
  assign winner    = pick_winner(io_pend, dma_pend, cpu_pend, cpu_force);
  // DONE can start the next grant directly, leaving only one dead cycle on mem_req.
  assign can_grant = (state != ISSUE) && any_pend;
  assign rd_done   = (state == ISSUE) && mem_ack && !mem_we;
  assign busy      = (state != IDLE);

  mem_arb_slot #(.AW(AW)) u_io_slot (
    .clk(clk), .reset(reset), .req(io_req), .we(1'b1), .addr(io_addr), .din(io_din),
    .grant(can_grant && (winner == GID_IO)), .rd_load(1'b0), .rd_data(8'h00),
    .pending(io_pend), .cap_we(io_cwe), .cap_addr(io_caddr), .cap_din(io_cdin),
    .dout(io_dout_unused)
  );

  mem_arb_slot #(.AW(AW)) u_dma_slot (
    .clk(clk), .reset(reset), .req(dma_req), .we(1'b0), .addr(dma_addr), .din(8'h00),
    .grant(can_grant && (winner == GID_DMA)), .rd_load(rd_done && (grant_id == GID_DMA)),
    .rd_data(mem_dout), .pending(dma_pend), .cap_we(dma_cwe), .cap_addr(dma_caddr),
    .cap_din(dma_cdin), .dout(dma_dout)
  );

  mem_arb_slot #(.AW(AW)) u_cpu_slot (
    .clk(clk), .reset(reset), .req(cpu_req), .we(cpu_we), .addr(cpu_addr), .din(cpu_din),
    .grant(can_grant && (winner == GID_CPU)), .rd_load(rd_done && (grant_id == GID_CPU)),
    .rd_data(mem_dout), .pending(cpu_pend), .cap_we(cpu_cwe), .cap_addr(cpu_caddr),
    .cap_din(cpu_cdin), .dout(cpu_dout)
  );

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_din  = 8'h00;
    case (winner)
      GID_IO:  begin sel_we = io_cwe;  sel_addr = io_caddr;  sel_din = io_cdin;  end
      GID_DMA: begin sel_we = dma_cwe; sel_addr = dma_caddr; sel_din = dma_cdin; end
      GID_CPU: begin sel_we = cpu_cwe; sel_addr = cpu_caddr; sel_din = cpu_cdin; end
      default: ;
    endcase
  end

  // Command sequencer; the ack pulse and mem_req drop are both registered on mem_ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      starve   <= 3'd0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 8'h00;
      grant_id <= GID_NONE;
      io_ack   <= 1'b0;
      dma_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
    end else begin
      io_ack  <= 1'b0;
      dma_ack <= 1'b0;
      cpu_ack <= 1'b0;
      if (!cpu_pend) starve <= 3'd0;
      case (state)
        IDLE, DONE: begin
          if (can_grant) begin
            state    <= ISSUE;
            mem_req  <= 1'b1;
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            grant_id <= winner;
            if (cpu_pend) starve <= (winner == GID_CPU) ? 3'd0 : starve + 3'd1;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 8'h00;
            grant_id <= GID_NONE;
            io_ack   <= (grant_id == GID_IO);
            dma_ack  <= (grant_id == GID_DMA);
            cpu_ack  <= (grant_id == GID_CPU);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apogee_mem_arb.sv
// Directed bench for apogee_mem_arb: hand-timed strobes and memory acks, checked cycle by cycle.
module tb_apogee_mem_arb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_req = 1'b0, dma_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [24:0] io_addr = '0, dma_addr = '0, cpu_addr = '0;
  logic [7:0]  io_din = 8'h00, cpu_din = 8'h00, mem_dout = 8'h00;
  logic        mem_ack = 1'b0;
  logic        io_ack, dma_ack, cpu_ack, mem_req, mem_we, busy;
  logic [7:0]  dma_dout, cpu_dout, mem_din;
  logic [24:0] mem_addr;
  logic [1:0]  grant_id;

  int vectors = 0;
  int miscompares = 0;

  apogee_mem_arb #(.AW(25), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .io_req(io_req), .io_addr(io_addr), .io_din(io_din), .io_ack(io_ack),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_ack(dma_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ack(mem_ack), .grant_id(grant_id), .busy(busy)
  );

  always #10 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle strobe on the selected ports, all using the same address.
  task automatic applyStimulus(input logic io_s, input logic dma_s, input logic cpu_s,
                               input logic we, input logic [24:0] a, input logic [7:0] d);
    io_req = io_s;   io_addr = a;  io_din = d;
    dma_req = dma_s; dma_addr = a;
    cpu_req = cpu_s; cpu_we = we; cpu_addr = a; cpu_din = d;
    step();
    io_req = 1'b0; dma_req = 1'b0; cpu_req = 1'b0;
  endtask

  // Acks every outstanding command with read data 0 until the arbiter is idle.
  task automatic drain();
    int n;
    n = 0;
    mem_dout = 8'h00;
    while ((busy || mem_req) && n < 40) begin
      mem_ack = mem_req;
      step();
      n++;
    end
    mem_ack = 1'b0;
    step();
    checkOutput("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    step();
    step();
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_grant", {30'd0, grant_id}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    reset = 1'b0;
    step();

    // CPU read at 0x123, memory answers 2 cycles after mem_req rises
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 25'h00123, 8'h00);
    checkOutput("t1_n1_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    checkOutput("t1_n2_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("t1_n2_grant", {30'd0, grant_id}, 32'd3);
    checkOutput("t1_n2_addr", {7'd0, mem_addr}, 32'h123);
    checkOutput("t1_n2_we", {31'd0, mem_we}, 32'd0);
    step();
    checkOutput("t1_n3_mem_req", {31'd0, mem_req}, 32'd1);
    step();
    checkOutput("t1_n4_mem_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_dout = 8'h5A;
    step();
    mem_ack = 1'b0; mem_dout = 8'h00;
    checkOutput("t1_n5_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t1_n5_cpu_dout", {24'd0, cpu_dout}, 32'h5A);
    checkOutput("t1_n5_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("t1_n5_grant", {30'd0, grant_id}, 32'd0);
    step();
    checkOutput("t1_n6_cpu_ack", {31'd0, cpu_ack}, 32'd0);
    checkOutput("t1_n6_busy", {31'd0, busy}, 32'd0);

    // io and cpu strobed together: io first, cpu after one dead cycle
    io_req = 1'b1; io_addr = 25'h00040; io_din = 8'hC3;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h00050; cpu_din = 8'h44;
    step();
    io_req = 1'b0; cpu_req = 1'b0;
    step();
    checkOutput("t2_io_grant", {30'd0, grant_id}, 32'd1);
    checkOutput("t2_io_addr", {7'd0, mem_addr}, 32'h40);
    checkOutput("t2_io_we", {31'd0, mem_we}, 32'd1);
    checkOutput("t2_io_din", {24'd0, mem_din}, 32'hC3);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("t2_io_ack", {31'd0, io_ack}, 32'd1);
    checkOutput("t2_cpu_ack_early", {31'd0, cpu_ack}, 32'd0);
    checkOutput("t2_dead_mem_req", {31'd0, mem_req}, 32'd0);
    step();
    checkOutput("t2_cpu_grant", {30'd0, grant_id}, 32'd3);
    checkOutput("t2_cpu_mem_req", {31'd0, mem_req}, 32'd1);
    checkOutput("t2_io_ack_once", {31'd0, io_ack}, 32'd0);
    checkOutput("t2_cpu_addr", {7'd0, mem_addr}, 32'h50);
    mem_ack = 1'b1; mem_dout = 8'hEE;
    step();
    mem_ack = 1'b0; mem_dout = 8'h00;
    checkOutput("t2_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t2_wr_dout_kept", {24'd0, cpu_dout}, 32'h5A);
    step();
    checkOutput("t2_cpu_ack_once", {31'd0, cpu_ack}, 32'd0);
    checkOutput("t2_idle", {31'd0, busy}, 32'd0);

    // Starvation guard: io/dma strobed every cycle, one CPU read waiting
    io_req = 1'b1; dma_req = 1'b1; io_addr = 25'h00100; dma_addr = 25'h00200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h00300;
    step();
    cpu_req = 1'b0;
    step();
    for (int g = 1; g <= 5; g++) begin
      if (g == 5) begin
        io_req = 1'b0; dma_req = 1'b0;
        checkOutput("t3_starve_cleared", {29'd0, dut.starve}, 32'd0);
      end
      if (g == 4) checkOutput("t3_starve_max", {29'd0, dut.starve}, 32'd4);
      checkOutput($sformatf("t3_grant%0d", g), {30'd0, grant_id},
                  (g < 5) ? 32'd1 : 32'd3);
      mem_ack = 1'b1; mem_dout = 8'h9C;
      step();
      mem_ack = 1'b0; mem_dout = 8'h00;
      if (g < 5) step();
    end
    checkOutput("t3_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t3_cpu_dout", {24'd0, cpu_dout}, 32'h9C);
    drain();
    checkOutput("t3_dma_dout", {24'd0, dma_dout}, 32'h00);

    // Two CPU strobes while an io write is in flight: only the latest is issued
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 25'h00777, 8'h12);
    step();
    checkOutput("t4_io_grant", {30'd0, grant_id}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 25'h00010, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 25'h00020, 8'h00);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    checkOutput("t4_cpu_grant", {30'd0, grant_id}, 32'd3);
    checkOutput("t4_cpu_addr", {7'd0, mem_addr}, 32'h20);
    mem_ack = 1'b1; mem_dout = 8'hA5;
    step();
    mem_ack = 1'b0; mem_dout = 8'h00;
    checkOutput("t4_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t4_cpu_dout", {24'd0, cpu_dout}, 32'hA5);
    step();
    step();
    checkOutput("t4_no_second_req", {31'd0, mem_req}, 32'd0);
    checkOutput("t4_no_second_ack", {31'd0, cpu_ack}, 32'd0);

    // Reset in ISSUE, then a late mem_ack
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 25'h00abc, 8'h00);
    step();
    checkOutput("t5_issue", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    step();
    checkOutput("t5_rst_mem_req", {31'd0, mem_req}, 32'd0);
    reset = 1'b0;
    step();
    mem_ack = 1'b1; mem_dout = 8'h66;
    step();
    mem_ack = 1'b0; mem_dout = 8'h00;
    step();
    checkOutput("t5_dma_ack", {31'd0, dma_ack}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_grant", {30'd0, grant_id}, 32'd0);
    checkOutput("t5_dma_dout", {24'd0, dma_dout}, 32'd0);
    checkOutput("t5_cpu_dout", {24'd0, cpu_dout}, 32'd0);

    // DMA read 0x33, then a CPU write of 0x77
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 25'h00400, 8'h00);
    step();
    checkOutput("t6_dma_we", {31'd0, mem_we}, 32'd0);
    mem_ack = 1'b1; mem_dout = 8'h33;
    step();
    mem_ack = 1'b0; mem_dout = 8'h00;
    checkOutput("t6_dma_ack", {31'd0, dma_ack}, 32'd1);
    checkOutput("t6_dma_dout", {24'd0, dma_dout}, 32'h33);
    step();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 25'h00500, 8'h77);
    step();
    checkOutput("t6_cpu_we", {31'd0, mem_we}, 32'd1);
    checkOutput("t6_cpu_din", {24'd0, mem_din}, 32'h77);
    mem_ack = 1'b1; mem_dout = 8'hF0;
    step();
    mem_ack = 1'b0; mem_dout = 8'h00;
    checkOutput("t6_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    checkOutput("t6_dma_dout_kept", {24'd0, dma_dout}, 32'h33);
    checkOutput("t6_cpu_dout_kept", {24'd0, cpu_dout}, 32'h00);
    step();

    // Stray mem_ack while idle
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checkOutput("t7_stray_ack", {29'd0, io_ack, dma_ack, cpu_ack}, 32'd0);
    checkOutput("t7_stray_busy", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
